// File: rtl/conv_controller_param.sv
// Convolution loop controller: sequences kernel loads, per-row column prefetch,
// per-pixel compute beats and output emission over a run-time sized feature map.
module conv_controller_param #(
    parameter int COORD_W      = 16,
    parameter int CH_W         = 16,
    parameter int CH_PAR       = 6,
    parameter int LOAD_K_BEATS = 72,
    parameter int LOAD_I_BEATS = 4,
    parameter int PRE_COLS     = 2,
    parameter int CALC_BEATS   = 6,
    parameter int OUT_BEATS    = 2
) (
    input  logic                            clk,
    input  logic                            rst_in,
    input  logic                            start,
    input  logic [COORD_W-1:0]              cfg_width,
    input  logic [COORD_W-1:0]              cfg_height,
    input  logic [CH_W-1:0]                 cfg_out_ch,
    output logic                            running,
    output logic                            done,
    input  logic                            con_valid,
    output logic                            con_ready,
    input  logic                            out_ready,
    output logic                            output_valid,
    output logic [COORD_W-1:0]              output_x,
    output logic [COORD_W-1:0]              output_y,
    output logic [CH_W-1:0]                 output_ch,
    output logic                            ctrl_k_load_en,
    output logic [$clog2(LOAD_K_BEATS)-1:0] ctrl_k_load_idx,
    output logic                            ctrl_i_load_en,
    output logic [$clog2(LOAD_I_BEATS)-1:0] ctrl_i_load_idx,
    output logic                            ctrl_i_shift,
    output logic                            ctrl_calc_en,
    output logic [$clog2(CALC_BEATS)-1:0]   ctrl_calc_beat,
    output logic                            ctrl_acc_clear
);

    localparam int K_W    = $clog2(LOAD_K_BEATS);
    localparam int I_W    = $clog2(LOAD_I_BEATS);
    localparam int C_W    = $clog2(CALC_BEATS);
    localparam int BEAT_W = (K_W > C_W) ? K_W : C_W;
    localparam int OB_W   = (OUT_BEATS > 1) ? $clog2(OUT_BEATS) : 1;
    localparam int COL_W  = $clog2(PRE_COLS + 1);

    localparam logic [BEAT_W-1:0] K_LAST    = BEAT_W'(LOAD_K_BEATS - 1);
    localparam logic [BEAT_W-1:0] I_LAST    = BEAT_W'(LOAD_I_BEATS - 1);
    localparam logic [BEAT_W-1:0] C_LAST    = BEAT_W'(CALC_BEATS - 1);
    localparam logic [BEAT_W:0]   I_BEATS_X = (BEAT_W + 1)'(LOAD_I_BEATS);
    localparam logic [OB_W-1:0]   OB_LAST   = OB_W'(OUT_BEATS - 1);
    localparam logic [COL_W-1:0]  COL_LAST  = COL_W'(PRE_COLS - 1);
    localparam logic [CH_W-1:0]   CH_STEP   = CH_W'(CH_PAR / OUT_BEATS);
    localparam logic [CH_W:0]     CH_GROUP  = (CH_W + 1)'(CH_PAR);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD_K  = 3'd1;
    localparam logic [2:0] S_LOAD_I  = 3'd2;
    localparam logic [2:0] S_SHIFT_I = 3'd3;
    localparam logic [2:0] S_CALC    = 3'd4;
    localparam logic [2:0] S_OUT     = 3'd5;
    localparam logic [2:0] S_FIN     = 3'd6;

    logic [2:0]         state;
    logic [BEAT_W-1:0]  beat;
    logic [COL_W-1:0]   col;
    logic [OB_W-1:0]    obeat;
    logic [COORD_W-1:0] x;
    logic [COORD_W-1:0] y;
    logic [CH_W-1:0]    ch_base;
    logic [COORD_W-1:0] cfg_w;
    logic [COORD_W-1:0] cfg_h;
    logic [CH_W-1:0]    cfg_ch;

    logic               load_phase;
    logic               hs;
    logic               calc_adv;
    logic [CH_W:0]      ch_next;

    // The first LOAD_I_BEATS compute beats double as input-word loads and
    // therefore only advance on a handshake.
    always_comb begin
        load_phase      = ({1'b0, beat} < I_BEATS_X);
        con_ready       = (state == S_LOAD_K) || (state == S_LOAD_I) ||
                          ((state == S_CALC) && load_phase);
        hs              = con_valid && con_ready;
        calc_adv        = (state == S_CALC) && (load_phase ? hs : 1'b1);
        ch_next         = {1'b0, ch_base} + CH_GROUP;

        running         = (state != S_IDLE);
        done            = (state == S_FIN);
        ctrl_k_load_en  = hs && (state == S_LOAD_K);
        ctrl_k_load_idx = '0;
        ctrl_i_load_en  = hs && ((state == S_LOAD_I) || (state == S_CALC));
        ctrl_i_load_idx = '0;
        ctrl_i_shift    = (state == S_SHIFT_I) || (calc_adv && (beat == C_LAST));
        ctrl_calc_en    = calc_adv;
        ctrl_calc_beat  = '0;
        ctrl_acc_clear  = (state == S_CALC) && (beat == '0);
        output_valid    = (state == S_OUT);
        output_x        = '0;
        output_y        = '0;
        output_ch       = '0;

        if (state == S_LOAD_K)
            ctrl_k_load_idx = beat[K_W-1:0];
        if ((state == S_LOAD_I) || ((state == S_CALC) && load_phase))
            ctrl_i_load_idx = beat[I_W-1:0];
        if (state == S_CALC)
            ctrl_calc_beat = beat[C_W-1:0];
        if (state == S_OUT) begin
            output_x  = x;
            output_y  = y;
            output_ch = ch_base + CH_W'(obeat) * CH_STEP;
        end
    end

    always_ff @(posedge clk) begin
        if (rst_in) begin
            state   <= S_IDLE;
            beat    <= '0;
            col     <= '0;
            obeat   <= '0;
            x       <= '0;
            y       <= '0;
            ch_base <= '0;
            cfg_w   <= '0;
            cfg_h   <= '0;
            cfg_ch  <= '0;
        end else begin
            case (state)
                S_IDLE: begin
                    if (start) begin
                        cfg_w   <= cfg_width;
                        cfg_h   <= cfg_height;
                        cfg_ch  <= cfg_out_ch;
                        x       <= '0;
                        y       <= '0;
                        ch_base <= '0;
                        beat    <= '0;
                        col     <= '0;
                        obeat   <= '0;
                        if ((cfg_width == '0) || (cfg_height == '0) || (cfg_out_ch == '0))
                            state <= S_FIN;
                        else
                            state <= S_LOAD_K;
                    end
                end
                S_LOAD_K: begin
                    if (hs) begin
                        if (beat == K_LAST) begin
                            beat  <= '0;
                            col   <= '0;
                            state <= S_LOAD_I;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_LOAD_I: begin
                    if (hs) begin
                        if (beat == I_LAST) begin
                            beat  <= '0;
                            state <= S_SHIFT_I;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                S_SHIFT_I: begin
                    col   <= col + 1'b1;
                    state <= (col == COL_LAST) ? S_CALC : S_LOAD_I;
                end
                S_CALC: begin
                    if (calc_adv) begin
                        if (beat == C_LAST) begin
                            beat  <= '0;
                            obeat <= '0;
                            state <= S_OUT;
                        end else begin
                            beat <= beat + 1'b1;
                        end
                    end
                end
                // Loop nest: channel group outermost, then row, then column.
                S_OUT: begin
                    if (out_ready) begin
                        if (obeat != OB_LAST) begin
                            obeat <= obeat + 1'b1;
                        end else begin
                            obeat <= '0;
                            if (x != cfg_w - 1'b1) begin
                                x     <= x + 1'b1;
                                state <= S_CALC;
                            end else if (y != cfg_h - 1'b1) begin
                                x     <= '0;
                                y     <= y + 1'b1;
                                col   <= '0;
                                state <= S_LOAD_I;
                            end else if (ch_next < {1'b0, cfg_ch}) begin
                                x       <= '0;
                                y       <= '0;
                                ch_base <= ch_next[CH_W-1:0];
                                state   <= S_LOAD_K;
                            end else begin
                                state <= S_FIN;
                            end
                        end
                    end
                end
                S_FIN: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_conv_controller_param.sv
// Scoreboard bench for conv_controller_param: directed jobs push expected
// output words and transfer counts; a negedge monitor pops and compares.
module tb_conv_controller_param;

    localparam int COORD_W      = 16;
    localparam int CH_W         = 16;
    localparam int CH_PAR       = 6;
    localparam int LOAD_K_BEATS = 72;
    localparam int LOAD_I_BEATS = 4;
    localparam int PRE_COLS     = 2;
    localparam int CALC_BEATS   = 6;
    localparam int OUT_BEATS    = 2;

    logic               clk;
    logic               rst_in;
    logic               start;
    logic [COORD_W-1:0] cfg_width;
    logic [COORD_W-1:0] cfg_height;
    logic [CH_W-1:0]    cfg_out_ch;
    logic               running;
    logic               done;
    logic               con_valid;
    logic               con_ready;
    logic               out_ready;
    logic               output_valid;
    logic [COORD_W-1:0] output_x;
    logic [COORD_W-1:0] output_y;
    logic [CH_W-1:0]    output_ch;
    logic               ctrl_k_load_en;
    logic [6:0]         ctrl_k_load_idx;
    logic               ctrl_i_load_en;
    logic [1:0]         ctrl_i_load_idx;
    logic               ctrl_i_shift;
    logic               ctrl_calc_en;
    logic [2:0]         ctrl_calc_beat;
    logic               ctrl_acc_clear;

    logic [47:0] exp_q[$];
    int          checks;
    int          errors;
    int          k_cnt;
    int          i_cnt;
    int          shift_cnt;
    int          calc_cnt;
    int          clear_cnt;
    int          k_seq;
    int          i_seq;
    bit          toggle_mode;
    logic        mon_hs;

    conv_controller_param #(
        .COORD_W(COORD_W), .CH_W(CH_W), .CH_PAR(CH_PAR),
        .LOAD_K_BEATS(LOAD_K_BEATS), .LOAD_I_BEATS(LOAD_I_BEATS),
        .PRE_COLS(PRE_COLS), .CALC_BEATS(CALC_BEATS), .OUT_BEATS(OUT_BEATS)
    ) dut (
        .clk(clk), .rst_in(rst_in), .start(start),
        .cfg_width(cfg_width), .cfg_height(cfg_height), .cfg_out_ch(cfg_out_ch),
        .running(running), .done(done),
        .con_valid(con_valid), .con_ready(con_ready),
        .out_ready(out_ready), .output_valid(output_valid),
        .output_x(output_x), .output_y(output_y), .output_ch(output_ch),
        .ctrl_k_load_en(ctrl_k_load_en), .ctrl_k_load_idx(ctrl_k_load_idx),
        .ctrl_i_load_en(ctrl_i_load_en), .ctrl_i_load_idx(ctrl_i_load_idx),
        .ctrl_i_shift(ctrl_i_shift), .ctrl_calc_en(ctrl_calc_en),
        .ctrl_calc_beat(ctrl_calc_beat), .ctrl_acc_clear(ctrl_acc_clear)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // con_valid is either held high or toggled every cycle to create stalls.
    initial begin
        con_valid = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (toggle_mode)
                con_valid = ~con_valid;
            else
                con_valid = 1'b1;
        end
    end

    task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
        end
    endtask

    // Monitor: every handshake must raise exactly one load enable, load slots
    // must walk their sequences, and every accepted output word is scored.
    initial begin
        forever begin
            @(negedge clk);
            if (rst_in) begin
                k_seq = 0;
                i_seq = 0;
            end else begin
                mon_hs = con_valid && con_ready;
                if (mon_hs || ctrl_k_load_en || ctrl_i_load_en)
                    checkOutput("load_en", 64'(ctrl_k_load_en) + 64'(ctrl_i_load_en), 64'(mon_hs));
                if (ctrl_k_load_en) begin
                    checkOutput("k_idx", 64'(ctrl_k_load_idx), 64'(k_seq % LOAD_K_BEATS));
                    k_seq++;
                    k_cnt++;
                end
                if (ctrl_i_load_en) begin
                    checkOutput("i_idx", 64'(ctrl_i_load_idx), 64'(i_seq % LOAD_I_BEATS));
                    i_seq++;
                    i_cnt++;
                end
                if (ctrl_i_shift) shift_cnt++;
                if (ctrl_calc_en) calc_cnt++;
                if (ctrl_calc_en && ctrl_acc_clear) clear_cnt++;
                if (output_valid && out_ready) begin
                    checkOutput("out_pending", 64'(exp_q.size() != 0), 64'(1));
                    if (exp_q.size() != 0)
                        checkOutput("out_word", 64'({output_x, output_y, output_ch}), 64'(exp_q.pop_front()));
                end
            end
        end
    end

    task automatic applyStimulus(input int w, input int h, input int och, input bit toggle, input bit stall);
        int  groups;
        int  k0, i0, s0, c0, cl0;
        int  done_cnt;
        int  done_cyc;
        bit  finished;
        bit  stalled;
        bit  zero;
        zero     = (w == 0) || (h == 0) || (och == 0);
        groups   = zero ? 0 : (och + CH_PAR - 1) / CH_PAR;
        done_cnt = 0;
        done_cyc = 0;
        finished = 0;
        stalled  = 0;
        for (int g = 0; g < groups; g++)
            for (int yy = 0; yy < h; yy++)
                for (int xx = 0; xx < w; xx++)
                    for (int ob = 0; ob < OUT_BEATS; ob++)
                        exp_q.push_back({16'(xx), 16'(yy), 16'(g * CH_PAR + ob * (CH_PAR / OUT_BEATS))});
        k0 = k_cnt; i0 = i_cnt; s0 = shift_cnt; c0 = calc_cnt; cl0 = clear_cnt;
        toggle_mode = toggle;
        out_ready   = !stall;
        cfg_width   = 16'(w);
        cfg_height  = 16'(h);
        cfg_out_ch  = 16'(och);
        start       = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        for (int cyc = 1; cyc <= 6000 && !finished; cyc++) begin
            @(negedge clk);
            if (done) begin
                done_cnt++;
                done_cyc = cyc;
            end
            if (stall && !stalled && output_valid) begin
                stalled = 1;
                for (int s = 0; s < 5; s++) begin
                    @(posedge clk);
                    #1;
                    checkOutput("stall_valid", 64'(output_valid), 64'(1));
                    checkOutput("stall_xy_ch", 64'({output_x, output_y, output_ch}), 64'(48'h0));
                    checkOutput("stall_con_ready", 64'(con_ready), 64'(0));
                end
                out_ready = 1'b1;
            end
            if (!running) finished = 1;
        end
        checkOutput("job_end", 64'(finished), 64'(1));
        checkOutput("done_pulses", 64'(done_cnt), 64'(1));
        checkOutput("k_handshakes", 64'(k_cnt - k0), 64'(groups * LOAD_K_BEATS));
        checkOutput("i_handshakes", 64'(i_cnt - i0), 64'(groups * h * (PRE_COLS + w) * LOAD_I_BEATS));
        checkOutput("shifts", 64'(shift_cnt - s0), 64'(groups * h * (PRE_COLS + w)));
        checkOutput("calc_beats", 64'(calc_cnt - c0), 64'(groups * h * w * CALC_BEATS));
        checkOutput("acc_clears", 64'(clear_cnt - cl0), 64'(groups * h * w));
        checkOutput("out_missing", 64'(exp_q.size()), 64'(0));
        if (zero)
            checkOutput("zero_done_cycle", 64'(done_cyc), 64'(1));
        exp_q.delete();
        toggle_mode = 0;
        out_ready   = 1'b1;
    endtask

    initial begin
        bit found;
        checks = 0; errors = 0;
        k_cnt = 0; i_cnt = 0; shift_cnt = 0; calc_cnt = 0; clear_cnt = 0;
        k_seq = 0; i_seq = 0;
        toggle_mode = 0;
        rst_in = 1'b1; start = 1'b0; out_ready = 1'b1;
        cfg_width = '0; cfg_height = '0; cfg_out_ch = '0;
        repeat (3) @(posedge clk);
        #1;
        checkOutput("rst_running", 64'(running), 64'(0));
        checkOutput("rst_done", 64'(done), 64'(0));
        checkOutput("rst_con_ready", 64'(con_ready), 64'(0));
        checkOutput("rst_output_valid", 64'(output_valid), 64'(0));
        checkOutput("rst_k_idx", 64'(ctrl_k_load_idx), 64'(0));
        checkOutput("rst_calc_en", 64'(ctrl_calc_en), 64'(0));
        rst_in = 1'b0;
        @(posedge clk);
        #1;

        applyStimulus(2, 2, 6, 0, 0);
        applyStimulus(1, 1, 12, 0, 0);
        applyStimulus(1, 1, 6, 0, 1);
        applyStimulus(2, 1, 6, 1, 0);
        applyStimulus(3, 2, 7, 0, 0);
        applyStimulus(0, 3, 6, 0, 0);

        // Abort a job in the middle of its compute beats.
        cfg_width = 16'd2; cfg_height = 16'd2; cfg_out_ch = 16'd6;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        found = 0;
        for (int cyc = 0; cyc < 3000 && !found; cyc++) begin
            @(negedge clk);
            if (ctrl_calc_en && (ctrl_calc_beat == 3'd4)) found = 1;
        end
        checkOutput("calc_reached", 64'(found), 64'(1));
        @(posedge clk);
        #1;
        rst_in = 1'b1;
        @(posedge clk);
        #1;
        checkOutput("abort_running", 64'(running), 64'(0));
        checkOutput("abort_done", 64'(done), 64'(0));
        checkOutput("abort_con_ready", 64'(con_ready), 64'(0));
        checkOutput("abort_output_valid", 64'(output_valid), 64'(0));
        checkOutput("abort_calc_en", 64'(ctrl_calc_en), 64'(0));
        checkOutput("abort_shift", 64'(ctrl_i_shift), 64'(0));
        rst_in = 1'b0;
        exp_q.delete();
        @(posedge clk);
        #1;
        applyStimulus(1, 1, 6, 0, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/conv_controller_param.md
Name: conv_controller_param

Overview:
Parametrised successor of the convolution loop controller. It sequences kernel loading, input-column prefetch, per-pixel compute beats and result emission over a feature map whose size and output channel count are set at run time. It drives the input and kernel datapath select lines and the external con_valid/con_ready handshake. It adds output backpressure (out_ready), a done pulse and fully counted loads, replacing the hard-coded state chains of the previous generation.

Parameters:
COORD_W, 16, width of the x/y counters and of cfg_width/cfg_height
CH_W, 16, width of the channel counter and of cfg_out_ch
CH_PAR, 6, output channels computed per channel group
LOAD_K_BEATS, 72, kernel words loaded per channel group
LOAD_I_BEATS, 4, input words per feature-map column
PRE_COLS, 2, columns prefetched at the start of each row
CALC_BEATS, 6, compute beats per pixel; must be >= LOAD_I_BEATS
OUT_BEATS, 2, output words per pixel; CH_PAR must be divisible by OUT_BEATS

Ports:
clk  in  1  clock
rst_in  in  1  synchronous reset, active high
start  in  1  start request, sampled only in IDLE
cfg_width  in  COORD_W  feature-map width, latched on accepted start
cfg_height  in  COORD_W  feature-map height, latched on accepted start
cfg_out_ch  in  CH_W  output channel count, latched on accepted start
running  out  1  high in every state except IDLE
done  out  1  one-cycle pulse at job end
con_valid  in  1  external data word valid
con_ready  out  1  controller accepts a data word
out_ready  in  1  downstream accepts an output word
output_valid  out  1  output word valid
output_x  out  COORD_W  x of the emitted pixel
output_y  out  COORD_W  y of the emitted pixel
output_ch  out  CH_W  first channel carried by the current output word
ctrl_k_load_en  out  1  write the kernel word (asserted when con_valid&&con_ready in LOAD_K)
ctrl_k_load_idx  out  $clog2(LOAD_K_BEATS)  kernel word slot
ctrl_i_load_en  out  1  write the input word (asserted on handshake in LOAD_I or CALC)
ctrl_i_load_idx  out  $clog2(LOAD_I_BEATS)  input word slot
ctrl_i_shift  out  1  shift the input column window
ctrl_calc_en  out  1  MAC beat enable
ctrl_calc_beat  out  $clog2(CALC_BEATS)  current compute beat
ctrl_acc_clear  out  1  clear accumulators (compute beat 0)

Behaviour:
- Reset: state is IDLE and all counters and config registers are 0. Every output is 0 except that ctrl_*_idx are 0.
- Reset has priority over all other events, including when it arrives mid-job; no done pulse is produced.
- The FSM is Moore-style on registered state. The handshake outputs are combinational from state and inputs.
- States: IDLE, LOAD_K, LOAD_I, SHIFT_I, CALC, OUT, FIN.
- IDLE:
  - On start, latch the config registers and clear x, y and ch_base.
  - If any config value is 0, go to FIN with no transfers. Otherwise go to LOAD_K.
- LOAD_K:
  - con_ready=1. beat increments on each handshake.
  - ctrl_k_load_idx = beat.
  - After handshake number LOAD_K_BEATS: beat=0, col=0, go to LOAD_I.
- LOAD_I:
  - con_ready=1. ctrl_i_load_idx = beat.
  - After handshake number LOAD_I_BEATS, go to SHIFT_I.
- SHIFT_I: one cycle with ctrl_i_shift=1 and col+1. If col reaches PRE_COLS, go to CALC; otherwise go to LOAD_I.
- CALC:
  - ctrl_calc_beat = beat and ctrl_acc_clear = (beat==0).
  - For beat < LOAD_I_BEATS: con_ready=1, ctrl_i_load_idx = beat, and the beat advances only on handshake. ctrl_calc_en is high only on handshake cycles.
  - For the remaining beats: ctrl_calc_en=1 and the beat advances every cycle.
  - The last beat also asserts ctrl_i_shift and goes to OUT.
- OUT:
  - output_valid=1. output_ch = ch_base + obeat*(CH_PAR/OUT_BEATS).
  - output_x and output_y hold the current pixel.
  - Outputs are stable while out_ready=0; obeat advances on valid&&ready.
  - After the last word, advance the loops:
    - x < cfg_width-1: x+1, go to CALC.
    - Else if y < cfg_height-1: x=0, y+1, go to LOAD_I.
    - Else if ch_base+CH_PAR < cfg_out_ch: x=y=0, ch_base+CH_PAR, go to LOAD_K.
    - Else go to FIN.
- FIN: done=1 for one cycle, then IDLE.
- Loop order: channel group (outer), then y, then x, then compute beats.
- Each row re-prefetches PRE_COLS columns.
- con_ready=0 in IDLE, SHIFT_I, OUT and FIN.
- start while running is ignored. Config inputs are don't-care after latching.
- The last channel group may exceed cfg_out_ch. It emits the full CH_PAR channels; the consumer discards the extras.
- All counters compare against latched config using equality on the width-1 boundary; there is no wrap beyond config.

Test Plan:
- Reset, then start with cfg 2x2, out_ch=6: transfers are 72 kernel, then 8 prefetch + 4+4 pixel words for each of 2 rows. Emits 8 output words: (0,0,ch0),(0,0,ch3),(1,0,..),…,(1,1,ch3). done pulses once, then running=0.
- out_ch=12, 1x1 map: LOAD_K is entered twice and output_ch takes the values 0,3,6,9. A total of 144 kernel handshakes.
- out_ready held low for 5 cycles in OUT: output_valid stays 1 and x/y/ch stay stable; no extra words and no state advance.
- con_valid toggling every other cycle during LOAD_K and CALC: ctrl_k_load_en and ctrl_i_load_en match the handshakes exactly, and the beat count is unaffected by stalls.
- start with cfg_width=0: FIN next cycle, done=1, and no con_ready or output_valid.
- rst_in asserted mid-CALC: IDLE on the next edge with all outputs 0. A new start then runs cleanly from LOAD_K.
